// File: rtl/sfp_norm_pkg.sv
// Shared types and constants for the sfp_norm special-function stage:
// FSM state encoding, default widths and the |psum| helper.
package sfp_pkg;

  localparam int COL      = 8;
  localparam int BW_PSUM  = 12;
  localparam int BW_SUM   = BW_PSUM + 4;
  localparam int FRAC_DEF = 8;

  typedef enum logic [2:0] {
    IDLE,
    ACC,
    PUSH,
    WAIT,
    DIV,
    DONE
  } state_t;

  // Unsigned magnitude; the most negative value maps to 2^(BW_PSUM-1).
  function automatic logic [BW_PSUM-1:0] abs_mag(input logic signed [BW_PSUM-1:0] v);
    logic [BW_PSUM-1:0] u;
    u = v;
    return v[BW_PSUM-1] ? (~u + 1'b1) : u;
  endfunction

endpackage

// File: rtl/sfp_norm_seq_divider.sv
// Unsigned restoring divider producing Q_W quotient bits, one per cycle.
// The caller guarantees (dividend >> Q_W) < divisor so Q_W iterations suffice.
module seq_divider
  import sfp_pkg::*;
#(
  parameter int DVD_W = 20,
  parameter int DVS_W = 17,
  parameter int Q_W   = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic [Q_W-1:0]   quo,
  output logic [DVS_W-1:0] rem,
  output logic             done
);

  localparam int CNT_W = $clog2(Q_W + 1);

  logic [DVS_W-1:0] rem_p0, rem_cur, rem_nxt;
  logic [Q_W-1:0]   low_p0, low_cur, quo_p0, quo_cur;
  logic [DVS_W+1:0] trial;
  logic             qbit;
  logic [CNT_W-1:0] cnt;
  logic             run;

  // The start cycle already performs the first iteration on the fresh operands.
  always_comb begin
    rem_cur = start ? DVS_W'(dividend >> Q_W) : rem_p0;
    low_cur = start ? dividend[Q_W-1:0] : low_p0;
    quo_cur = start ? '0 : quo_p0;
    trial   = {1'b0, rem_cur, low_cur[Q_W-1]} - {2'b00, divisor};
    qbit    = ~trial[DVS_W+1];
    rem_nxt = qbit ? trial[DVS_W-1:0] : {rem_cur[DVS_W-2:0], low_cur[Q_W-1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run  <= 1'b0;
      done <= 1'b0;
      cnt  <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        run <= 1'b1;
        cnt <= CNT_W'(1);
      end else if (run) begin
        cnt <= cnt + CNT_W'(1);
        if (cnt == CNT_W'(Q_W - 1)) begin
          run  <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (start || run) begin
      rem_p0 <= rem_nxt;
      low_p0 <= {low_cur[Q_W-2:0], 1'b0};
      quo_p0 <= {quo_cur[Q_W-2:0], qbit};
    end
  end

  assign quo = quo_p0;
  assign rem = rem_p0;

endmodule

// File: rtl/sfp_norm.sv
// Row |psum| sum, cross-core sum exchange and per-element normalization.
// Optional macro SFP_NORM_ROUND_EN: round quotients to nearest instead of truncating.
module sfp_norm
  import sfp_pkg::*;
#(
  parameter int col     = COL,
  parameter int bw_psum = BW_PSUM,
  parameter int bw_sum  = BW_SUM,
  parameter int FRAC    = FRAC_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [bw_psum*col-1:0] psum_in,
  output logic [bw_sum-1:0]      sum_out,
  output logic                   sum_wr,
  input  logic                   fifo_full,
  input  logic [bw_sum-1:0]      sum_in,
  input  logic                   fifo_empty,
  output logic                   sum_rd,
  output logic [bw_psum*col-1:0] out,
  output logic                   out_valid,
  output logic                   busy
);

  localparam int IDX_W = (col > 1) ? $clog2(col) : 1;
  localparam int Q_W   = FRAC + 1;
  localparam int DVD_W = bw_psum + FRAC;
  localparam int TOT_W = bw_sum + 1;

  state_t state, state_nxt;
  logic [IDX_W-1:0] col_idx, div_col;
  logic             last_col;

  logic signed [bw_psum-1:0] psum_p0 [col];
  logic [bw_sum-1:0]         acc_p1, acc_sum;
  logic [TOT_W-1:0]          total_p2, total_w;
  logic signed [bw_psum-1:0] res_p3 [col];
  logic [bw_psum*col-1:0]    out_pack;

  logic             div_start, div_done;
  logic [DVD_W-1:0] div_dividend;
  logic [TOT_W-1:0] div_divisor, div_rem;
  logic [Q_W-1:0]   div_quo, mag_q;
  logic signed [bw_psum-1:0] mag_s, res_w;

`ifdef SFP_NORM_ROUND_EN
  // Round half up; a quotient already at 2^FRAC is the largest legal magnitude.
  function automatic logic [Q_W-1:0] round_nearest(input logic [Q_W-1:0] q,
                                                   input logic [TOT_W-1:0] r,
                                                   input logic [TOT_W-1:0] d);
    if (({r, 1'b0} >= {1'b0, d}) && (q < Q_W'(1 << FRAC)))
      return q + 1'b1;
    return q;
  endfunction

  assign mag_q = round_nearest(div_quo, div_rem, total_p2);
`else
  logic unused_rem;
  assign unused_rem = ^div_rem;
  assign mag_q = div_quo;
`endif

  assign last_col = (col_idx == IDX_W'(col - 1));
  assign acc_sum  = acc_p1 + bw_sum'(abs_mag(psum_p0[col_idx]));
  assign total_w  = TOT_W'(sum_out) + TOT_W'(sum_in);
  assign busy     = (state != IDLE);

  assign div_dividend = DVD_W'(abs_mag(psum_p0[div_col])) << FRAC;
  assign div_divisor  = (state == WAIT) ? total_w : total_p2;

  assign mag_s = signed'(bw_psum'(mag_q));
  assign res_w = psum_p0[col_idx][bw_psum-1] ? -mag_s : mag_s;

  always_comb begin
    state_nxt = state;
    div_start = 1'b0;
    div_col   = '0;
    sum_wr    = 1'b0;
    sum_rd    = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = ACC;
      ACC:  if (last_col) state_nxt = PUSH;
      PUSH: if (!fifo_full) begin
        sum_wr    = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: if (!fifo_empty) begin
        sum_rd = 1'b1;
        if (total_w == '0) begin
          state_nxt = DONE;
        end else begin
          state_nxt = DIV;
          div_start = 1'b1;
        end
      end
      DIV: if (div_done) begin
        if (last_col) begin
          state_nxt = DONE;
        end else begin
          div_start = 1'b1;
          div_col   = col_idx + IDX_W'(1);
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (reset) begin
      sum_wr    = 1'b0;
      sum_rd    = 1'b0;
      div_start = 1'b0;
    end
  end

  always_comb begin
    out_pack = '0;
    for (int i = 0; i < col; i++) out_pack[i*bw_psum +: bw_psum] = res_p3[i];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      col_idx   <= '0;
      sum_out   <= '0;
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      out_valid <= 1'b0;
      case (state)
        IDLE: col_idx <= '0;
        ACC: begin
          col_idx <= last_col ? '0 : col_idx + IDX_W'(1);
          if (last_col) sum_out <= acc_sum;
        end
        DIV: if (div_done && !last_col) col_idx <= col_idx + IDX_W'(1);
        DONE: begin
          out       <= out_pack;
          out_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // p0: row capture, p1: |psum| accumulation, p2: two-core total, p3: per-column results
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      for (int i = 0; i < col; i++) begin
        psum_p0[i] <= psum_in[i*bw_psum +: bw_psum];
        res_p3[i]  <= '0;
      end
      acc_p1 <= '0;
    end
    if (state == ACC) acc_p1 <= acc_sum;
    if (state == WAIT && !fifo_empty) total_p2 <= total_w;
    if (state == DIV && div_done) res_p3[col_idx] <= res_w;
  end

  seq_divider #(
    .DVD_W(DVD_W),
    .DVS_W(TOT_W),
    .Q_W  (Q_W)
  ) u_div (
    .clk     (clk),
    .rst     (reset),
    .start   (div_start),
    .dividend(div_dividend),
    .divisor (div_divisor),
    .quo     (div_quo),
    .rem     (div_rem),
    .done    (div_done)
  );

endmodule

// File: tb/tb_sfp_norm.sv
// Scoreboard bench for sfp_norm: directed cases plus randomized rows and FIFO stalls,
// checked against an arithmetic reference model.
module tb_sfp_norm;

  localparam int NC  = 8;
  localparam int BWP = 12;
  localparam int BWS = 16;
  localparam int FR  = 8;

  logic clk = 1'b0;
  logic reset, start, fifo_full, fifo_empty;
  logic sum_wr, sum_rd, out_valid, busy;
  logic [BWP*NC-1:0] psum_in, out;
  logic [BWS-1:0]    sum_out, sum_in;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int start_cyc = 0;
  int ps_v[NC];

  typedef struct packed {
    logic [31:0]       lat;
    logic [BWP*NC-1:0] row;
  } out_exp_t;

  typedef struct packed {
    logic [31:0] off;
    logic [31:0] val;
  } wr_exp_t;

  out_exp_t out_q[$];
  wr_exp_t  wr_q[$];
  int       rd_q[$];
  out_exp_t mon_oe;
  wr_exp_t  mon_we;
  int       mon_rd;

  sfp_norm dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .psum_in   (psum_in),
    .sum_out   (sum_out),
    .sum_wr    (sum_wr),
    .fifo_full (fifo_full),
    .sum_in    (sum_in),
    .fifo_empty(fifo_empty),
    .sum_rd    (sum_rd),
    .out       (out),
    .out_valid (out_valid),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: out = sign(p) * (|p| * 2^FR) / (local + remote)
  function automatic int model_elem(input int p, input int total);
    int mag, q;
    if (total == 0) return 0;
    mag = (p < 0) ? -p : p;
    q = (mag * (1 << FR)) / total;
`ifdef SFP_NORM_ROUND_EN
    if (2 * ((mag * (1 << FR)) % total) >= total && q < (1 << FR)) q++;
`endif
    return (p < 0) ? -q : q;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_txn(input int remote, input int fcyc, input int ecyc,
                         input bit glitch, input int abort_at);
    int local_sum, total;
    out_exp_t oe;
    wr_exp_t we;
    logic [BWP-1:0] e;
    local_sum = 0;
    for (int i = 0; i < NC; i++) local_sum += (ps_v[i] < 0) ? -ps_v[i] : ps_v[i];
    total = local_sum + remote;
    for (int i = 0; i < NC; i++) begin
      e = BWP'(model_elem(ps_v[i], total));
      oe.row[i*BWP +: BWP] = e;
    end
    oe.lat = 32'((total == 0 ? 12 : 84) + fcyc + ecyc);
    we.off = 32'(9 + fcyc);
    we.val = 32'(local_sum);
    if (abort_at == 0) out_q.push_back(oe);
    wr_q.push_back(we);
    rd_q.push_back(10 + fcyc + ecyc);

    for (int i = 0; i < NC; i++) psum_in[i*BWP +: BWP] = BWP'(ps_v[i]);
    fifo_full  = (fcyc > 0);
    fifo_empty = 1'b1;
    sum_in     = BWS'($urandom);
    start      = 1'b1;
    start_cyc  = cyc;
    for (int c = 1; c <= 11 + fcyc + ecyc; c++) begin
      step();
      start = glitch && (c == 5);
      if (glitch && c == 5) psum_in = ~psum_in;
      if (c == 9 + fcyc) fifo_full = 1'b0;
      if (c == 10 + fcyc + ecyc) begin
        fifo_empty = 1'b0;
        sum_in     = BWS'(remote);
      end
      if (c == 11 + fcyc + ecyc) begin
        fifo_empty = 1'b1;
        sum_in     = BWS'($urandom);
      end
    end
    start = 1'b0;

    if (abort_at > 0) begin
      while (cyc - start_cyc < abort_at) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("abort_out_nonzero", longint'(out != '0), 0);
      check("abort_busy", busy, 0);
      check("abort_out_valid", out_valid, 0);
      check("abort_sum_wr", sum_wr, 0);
      check("abort_sum_rd", sum_rd, 0);
      repeat (100) begin
        step();
        if (sum_wr || sum_rd || busy) begin
          check("abort_quiet", 1, 0);
          break;
        end
      end
    end else begin
      int t;
      t = 0;
      while (busy && t < 300) begin
        step();
        t++;
      end
      if (busy) check("busy_timeout", 1, 0);
    end
    step();
    step();
  endtask

  always @(negedge clk) begin
    if (sum_wr && sum_rd) check("wr_rd_overlap", 1, 0);
    if (sum_wr) begin
      if (wr_q.size() == 0) begin
        check("unexpected_sum_wr", 1, 0);
      end else begin
        mon_we = wr_q.pop_front();
        check("sum_wr_cycle", cyc - start_cyc, longint'(mon_we.off));
        check("sum_out", sum_out, longint'(mon_we.val));
      end
    end
    if (sum_rd) begin
      if (rd_q.size() == 0) begin
        check("unexpected_sum_rd", 1, 0);
      end else begin
        mon_rd = rd_q.pop_front();
        check("sum_rd_cycle", cyc - start_cyc, mon_rd);
      end
    end
    if (out_valid) begin
      if (out_q.size() == 0) begin
        check("unexpected_out_valid", 1, 0);
      end else begin
        mon_oe = out_q.pop_front();
        check("latency", cyc - start_cyc, longint'(mon_oe.lat));
        for (int i = 0; i < NC; i++)
          check($sformatf("out[%0d]", i), $signed(out[i*BWP +: BWP]),
                $signed(mon_oe.row[i*BWP +: BWP]));
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    fifo_full = 1'b0;
    fifo_empty = 1'b1;
    sum_in = '0;
    psum_in = '0;
    repeat (3) step();
    check("rst_out_nonzero", longint'(out != '0), 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_sum_out", sum_out, 0);
    check("rst_sum_wr", sum_wr, 0);
    check("rst_sum_rd", sum_rd, 0);
    reset = 1'b0;
    step();

    for (int i = 0; i < NC; i++) ps_v[i] = 1;
    run_txn(8, 0, 0, 1'b0, 0);

    for (int i = 0; i < NC; i++) ps_v[i] = 0;
    ps_v[0] = -4;
    run_txn(4, 0, 0, 1'b0, 0);

    for (int i = 0; i < NC; i++) ps_v[i] = 0;
    run_txn(0, 0, 0, 1'b0, 0);

    for (int i = 0; i < NC; i++) ps_v[i] = i * 100 - 300;
    run_txn(1000, 5, 7, 1'b0, 0);

    for (int i = 0; i < NC; i++) ps_v[i] = 2047 - i * 500;
    run_txn(77, 0, 0, 1'b0, 30);

    for (int i = 0; i < NC; i++) ps_v[i] = (i % 2 == 0) ? 37 * i : -19 * i;
    run_txn(300, 0, 0, 1'b1, 0);

    for (int i = 0; i < NC; i++) ps_v[i] = 0;
    ps_v[0] = 1;
    run_txn(5, 0, 0, 1'b0, 0);

    for (int i = 0; i < NC; i++) ps_v[i] = 0;
    ps_v[0] = -2048;
    run_txn(0, 0, 0, 1'b0, 0);

    for (int i = 0; i < NC; i++) ps_v[i] = -2048;
    run_txn(65535, 1, 1, 1'b0, 0);

    for (int n = 0; n < 24; n++) begin
      int mode;
      mode = int'($urandom_range(0, 3));
      for (int i = 0; i < NC; i++) begin
        case (mode)
          0:       ps_v[i] = int'($urandom_range(0, 6)) - 3;
          1:       ps_v[i] = int'($urandom_range(0, 4095)) - 2048;
          2:       ps_v[i] = ($urandom_range(0, 2) == 0) ? -2048 : (($urandom_range(0, 1) == 0) ? 2047 : 0);
          default: ps_v[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 40)) - 20 : 0;
        endcase
      end
      if ($urandom_range(0, 7) == 0) begin
        for (int i = 0; i < NC; i++) ps_v[i] = 0;
        run_txn(0, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b0, 0);
      end else begin
        run_txn(($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 20)) : int'($urandom_range(0, 65535)),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                ($urandom_range(0, 4) == 0), 0);
      end
    end

    repeat (5) step();
    check("out_q_drained", out_q.size(), 0);
    check("wr_q_drained", wr_q.size(), 0);
    check("rd_q_drained", rd_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
